// File: rtl/brightness_adj.sv
// ---------------------------------------------------------------------------
// brightness_adj
//
// Per-pixel brightness adjuster. Adds a signed, optionally left-shifted
// offset to one unsigned colour sample per clock, clamps the result to
// [0, 2^DATA_W-1] and returns it through a single output register.
// When en_bp is low the sample passes through unchanged with the same
// one-clock latency.
//
// Parameters:
//   DATA_W      - colour sample width (unsigned)
//   PARAM_W     - brightness_param width (two's complement)
//   PARAM_SHIFT - left shift applied to brightness_param before the add
//
// Ports:
//   clk              in   pixel clock, rising edge
//   resetN           in   asynchronous active-low reset
//   en_bp            in   1 = apply offset, 0 = bypass
//   brightness_param in   signed offset, sampled every cycle
//   color_in         in   input pixel sample
//   color_out        out  adjusted pixel, registered
//   sat_flag         out  clamp indicator (only with BRIGHTNESS_SAT_FLAG_EN)
//
// Build option:
//   BRIGHTNESS_SAT_FLAG_EN - when defined, adds the registered sat_flag
//   output, high when en_bp=1 and the sum was clamped at either bound.
// ---------------------------------------------------------------------------
module brightness_adj #(
  parameter int DATA_W      = 8,
  parameter int PARAM_W     = 8,
  parameter int PARAM_SHIFT = 0
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               en_bp,
  input  logic [PARAM_W-1:0] brightness_param,
  input  logic [DATA_W-1:0]  color_in,
`ifdef BRIGHTNESS_SAT_FLAG_EN
  output logic [DATA_W-1:0]  color_out,
  output logic               sat_flag
`else
  output logic [DATA_W-1:0]  color_out
`endif
);

  // Wide enough that neither the shifted offset nor the sum can overflow.
  localparam int SUM_W = DATA_W + PARAM_W + PARAM_SHIFT + 2;

  localparam logic [DATA_W-1:0] MAX_VAL = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MIN_VAL = {DATA_W{1'b0}};

  logic [SUM_W-1:0]  w_param_ext;
  logic [SUM_W-1:0]  w_offset;
  logic [SUM_W-1:0]  w_color_ext;
  logic [SUM_W-1:0]  w_sum;
  logic              w_neg;
  logic              w_over;
  logic [DATA_W-1:0] w_adj;
  logic [DATA_W-1:0] w_next;
  logic              w_next_sat;

  logic [DATA_W-1:0] r_color_out;
  logic              r_sat_flag;

  // Sign-extend the parameter, zero-extend the pixel, form the signed sum.
  always_comb begin
    w_param_ext = {{(SUM_W-PARAM_W){brightness_param[PARAM_W-1]}}, brightness_param};
    w_offset    = w_param_ext << PARAM_SHIFT;
    w_color_ext = {{(SUM_W-DATA_W){1'b0}}, color_in};
    w_sum       = w_color_ext + w_offset;
  end

  // Clamp: the sign bit flags an underflow; any set bit between the sign
  // bit and the pixel field flags an overflow of a non-negative sum.
  always_comb begin
    w_neg  = w_sum[SUM_W-1];
    w_over = 1'b0;
    w_adj  = w_sum[DATA_W-1:0];
    if (w_neg) begin
      w_adj = MIN_VAL;
    end else if (|w_sum[SUM_W-2:DATA_W]) begin
      w_over = 1'b1;
      w_adj  = MAX_VAL;
    end else begin
      w_adj  = w_sum[DATA_W-1:0];
    end
  end

  // Bypass mux into the output register; the flag is only meaningful when
  // processing is enabled.
  always_comb begin
    w_next     = color_in;
    w_next_sat = 1'b0;
    if (en_bp) begin
      w_next     = w_adj;
      w_next_sat = w_neg | w_over;
    end else begin
      w_next     = color_in;
      w_next_sat = 1'b0;
    end
  end

  // Output register; asynchronous reset discards the pixel in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_color_out <= {DATA_W{1'b0}};
      r_sat_flag  <= 1'b0;
    end else begin
      r_color_out <= w_next;
      r_sat_flag  <= w_next_sat;
    end
  end

  assign color_out = r_color_out;

`ifdef BRIGHTNESS_SAT_FLAG_EN
  assign sat_flag = r_sat_flag;
`else
  logic w_unused_sat;
  assign w_unused_sat = r_sat_flag;
`endif

endmodule

// File: tb/tb_brightness_adj.sv
// ---------------------------------------------------------------------------
// tb_brightness_adj
//
// Self-checking bench for brightness_adj. Two instances: default build and
// a PARAM_SHIFT=2 build. Expected values are computed from the behavioural
// definition and queued when stimulus is driven; they are popped and
// compared one clock later, after the output register has updated.
// ---------------------------------------------------------------------------
module tb_brightness_adj;

  logic       clk;
  logic       resetN;
  logic       en_bp;
  logic [7:0] param;
  logic [7:0] color_in;
  logic [7:0] color_out;
  logic       s2_en;
  logic [7:0] s2_param;
  logic [7:0] s2_in;
  logic [7:0] s2_out;
`ifdef BRIGHTNESS_SAT_FLAG_EN
  logic       sat_flag;
  logic       s2_sat;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] q_exp[$];
  logic       q_sat[$];
  string      q_tag[$];
  logic [7:0] q2_exp[$];
  string      q2_tag[$];

  brightness_adj #(.DATA_W(8), .PARAM_W(8), .PARAM_SHIFT(0)) u_dut (
    .clk              (clk),
    .resetN           (resetN),
    .en_bp            (en_bp),
    .brightness_param (param),
`ifdef BRIGHTNESS_SAT_FLAG_EN
    .color_in         (color_in),
    .color_out        (color_out),
    .sat_flag         (sat_flag)
`else
    .color_in         (color_in),
    .color_out        (color_out)
`endif
  );

  brightness_adj #(.DATA_W(8), .PARAM_W(8), .PARAM_SHIFT(2)) u_dut2 (
    .clk              (clk),
    .resetN           (resetN),
    .en_bp            (s2_en),
    .brightness_param (s2_param),
`ifdef BRIGHTNESS_SAT_FLAG_EN
    .color_in         (s2_in),
    .color_out        (s2_out),
    .sat_flag         (s2_sat)
`else
    .color_in         (s2_in),
    .color_out        (s2_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and count it.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation of the default instance and compare.
  task automatic pop_check();
    logic [7:0] e;
    logic       es;
    string      t;
    if (q_exp.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty: got output with no expectation");
    end else begin
      e  = q_exp.pop_front();
      es = q_sat.pop_front();
      t  = q_tag.pop_front();
      check(t, color_out, e);
`ifdef BRIGHTNESS_SAT_FLAG_EN
      check({t, "_sat"}, {7'd0, sat_flag}, {7'd0, es});
`else
      if (es === 1'bx) $display("note: unknown sat expectation for %s", t);
`endif
    end
  endtask

  // One pixel through the default instance.
  task automatic cycle(input logic en, input logic [7:0] p, input logic [7:0] d,
                       input logic [7:0] e, input logic es, input string tag);
    @(negedge clk);
    en_bp    = en;
    param    = p;
    color_in = d;
    q_exp.push_back(e);
    q_sat.push_back(es);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // One pixel through the PARAM_SHIFT=2 instance.
  task automatic cycle2(input logic [7:0] p, input logic [7:0] d,
                        input logic [7:0] e, input string tag);
    string t;
    @(negedge clk);
    s2_en    = 1'b1;
    s2_param = p;
    s2_in    = d;
    q2_exp.push_back(e);
    q2_tag.push_back(tag);
    @(posedge clk);
    #1;
    if (q2_exp.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard2_empty: got output with no expectation");
    end else begin
      t = q2_tag.pop_front();
      check(t, s2_out, q2_exp.pop_front());
    end
  endtask

  initial begin
    logic [7:0] exp_v;
    resetN   = 1'b0;
    en_bp    = 1'b1;
    param    = 8'd0;
    color_in = 8'h80;
    s2_en    = 1'b0;
    s2_param = 8'd0;
    s2_in    = 8'h80;

    // Reset held across a rising edge: output stays zero.
    #2;
    check("reset_t2", color_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_after_edge", color_out, 8'h00);
    check("reset_dut2", s2_out, 8'h00);
    #3;
    resetN = 1'b1;

    // Ramp 0x00..0xFF with +1: top value saturates.
    for (int i = 0; i < 256; i++) begin
      exp_v = (i == 255) ? 8'hFF : 8'(i + 1);
      cycle(1'b1, 8'd1, 8'(i), exp_v, (i == 255), $sformatf("ramp_%0d", i));
    end

    // Identity with zero offset.
    cycle(1'b1, 8'd0, 8'h00, 8'h00, 1'b0, "ident_00");
    cycle(1'b1, 8'd0, 8'h5A, 8'h5A, 1'b0, "ident_5a");
    cycle(1'b1, 8'd0, 8'hFF, 8'hFF, 1'b0, "ident_ff");

    // Negative offset -16.
    cycle(1'b1, 8'hF0, 8'h05, 8'h00, 1'b1, "neg_05");
    cycle(1'b1, 8'hF0, 8'h10, 8'h00, 1'b0, "neg_10");
    cycle(1'b1, 8'hF0, 8'h80, 8'h70, 1'b0, "neg_80");
    cycle(1'b1, 8'h80, 8'h7F, 8'h00, 1'b1, "neg_min");

    // Bypass ignores the parameter.
    cycle(1'b0, 8'd100, 8'h00, 8'h00, 1'b0, "byp_00");
    cycle(1'b0, 8'd100, 8'hC8, 8'hC8, 1'b0, "byp_c8");
    cycle(1'b0, 8'd100, 8'hFF, 8'hFF, 1'b0, "byp_ff");

    // Mid-stream changes take effect on the same edge.
    cycle(1'b1, 8'd1,  8'hD0, 8'hD1, 1'b0, "mid_p1");
    cycle(1'b1, 8'd50, 8'hD0, 8'hFF, 1'b1, "mid_p50");
    cycle(1'b0, 8'd50, 8'hD0, 8'hD0, 1'b0, "mid_byp");
    cycle(1'b1, 8'd50, 8'hC0, 8'hF2, 1'b0, "mid_en");

    // Asynchronous reset between edges while streaming 0xAA.
    cycle(1'b1, 8'd0, 8'hAA, 8'hAA, 1'b0, "pre_rst");
    #3;
    resetN = 1'b0;
    #1;
    check("async_rst", color_out, 8'h00);
    @(posedge clk);
    #1;
    check("async_rst_hold", color_out, 8'h00);
    @(negedge clk);
    resetN = 1'b1;
    cycle(1'b1, 8'd0, 8'hAA, 8'hAA, 1'b0, "post_rst");
    cycle(1'b1, 8'd2, 8'hAA, 8'hAC, 1'b0, "post_rst2");

    // PARAM_SHIFT=2 build.
    cycle2(8'd3,  8'h10, 8'h1C, "sh2_p3");
    cycle2(8'h80, 8'hFF, 8'h00, "sh2_m128");
    cycle2(8'd63, 8'h05, 8'hFF, "sh2_over");
    cycle2(8'hFF, 8'h10, 8'h0C, "sh2_m1");

    if (q_exp.size() != 0 || q2_exp.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover: got %0d/%0d expected 0/0", q_exp.size(), q2_exp.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
